// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, constants and address-field helpers for the
// direct-mapped write-back data cache controller.
//   - state_t        : controller FSM states
//   - WORD_W/LINE_W  : word and line widths (4 words of 32 bits per line)
//   - MEM_IDX_W      : width of a backing-memory line index (16 lines)
//   - addr_*()       : split an 8-bit byte address into offset/index/tag/line
package dcache_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
    localparam int unsigned MEM_LINES      = 16;
    localparam int unsigned MEM_IDX_W      = $clog2(MEM_LINES);

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StReq,
        StWait,
        StFill
    } state_t;

    function automatic logic [1:0] addr_offset(input logic [7:0] a);
        return a[3:2];
    endfunction

    function automatic logic [3:0] addr_line(input logic [7:0] a);
        return a[7:4];
    endfunction

    // Index and tag come back zero-extended to 4 bits; callers slice them.
    function automatic logic [3:0] addr_index(input logic [7:0] a, input int unsigned idx_w);
        return a[7:4] & 4'((1 << idx_w) - 1);
    endfunction

    function automatic logic [3:0] addr_tag(input logic [7:0] a, input int unsigned idx_w);
        return a[7:4] >> idx_w;
    endfunction

    // Rebuild a memory line index from a stored tag and its set index.
    function automatic logic [3:0] make_line(input logic [3:0] tag, input logic [3:0] idx,
                                             input int unsigned idx_w);
        return (tag << idx_w) | idx;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Bus interfaces of the data cache controller.
//   dcache_cpu_if : CPU load/store stage <-> cache (CPU is master).
//     cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall back.
//   dcache_mem_if : cache <-> line-based data memory (cache is master).
//     Dc_rd_req/Dc_rd_addr line read, Dc_rline/Dc_rd_valid return,
//     Dc_wb_we/Dc_wb_addr/Dc_wb_wline victim write-back.
interface dcache_cpu_if #(
    parameter int unsigned XLEN = 32
);
    logic            cpu_req;
    logic            cpu_we;
    logic [XLEN-1:0] cpu_addr;
    logic [XLEN-1:0] cpu_wdata;
    logic [XLEN-1:0] cpu_rdata;
    logic            cpu_stall;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall
    );
endinterface

interface dcache_mem_if;
    import dcache_pkg::*;

    logic                 Dc_rd_req;
    logic [MEM_IDX_W-1:0] Dc_rd_addr;
    logic [LINE_W-1:0]    Dc_rline;
    logic                 Dc_rd_valid;
    logic                 Dc_wb_we;
    logic [MEM_IDX_W-1:0] Dc_wb_addr;
    logic [LINE_W-1:0]    Dc_wb_wline;

    modport master (
        output Dc_rd_req, Dc_rd_addr, Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        input  Dc_rline, Dc_rd_valid
    );

    modport slave (
        input  Dc_rd_req, Dc_rd_addr, Dc_wb_we, Dc_wb_addr, Dc_wb_wline,
        output Dc_rline, Dc_rd_valid
    );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage of the direct-mapped cache.
//   clk, rst         : clock, synchronous active-high reset (clears valid/dirty only)
//   i_rd_idx         : combinational read port set index
//   o_valid/o_dirty/o_tag/o_line : state of set i_rd_idx
//   i_ww_*           : single-word write port (store hit), sets dirty
//   i_fill_*         : whole-line fill port (refill), sets valid, clears dirty
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned TAG_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_line,
    input  logic              i_ww_en,
    input  logic [IDX_W-1:0]  i_ww_idx,
    input  logic [1:0]        i_ww_off,
    input  logic [WORD_W-1:0] i_ww_data,
    input  logic              i_fill_en,
    input  logic [IDX_W-1:0]  i_fill_idx,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [LINE_W-1:0] i_fill_line
);

    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [LINE_W-1:0]   r_data [NUM_SETS];

    assign o_valid = r_valid[i_rd_idx];
    assign o_dirty = r_dirty[i_rd_idx];
    assign o_tag   = r_tag[i_rd_idx];
    assign o_line  = r_data[i_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_fill_en) begin
                r_valid[i_fill_idx] <= 1'b1;
                r_dirty[i_fill_idx] <= 1'b0;
            end
            if (i_ww_en) begin
                r_dirty[i_ww_idx] <= 1'b1;
            end
        end
    end

    // Tags and data carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_fill_idx]  <= i_fill_tag;
            r_data[i_fill_idx] <= i_fill_line;
        end
        if (i_ww_en) begin
            r_data[i_ww_idx][WORD_W*i_ww_off +: WORD_W] <= i_ww_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   clk, rst : clock, synchronous active-high reset
//   cpu      : CPU request port (slave); hits answered combinationally,
//              misses stall the CPU until the line is installed
//   mem      : line memory port (master); registered read request and
//              victim write-back outputs
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_SETS = 4
) (
    input  logic         clk,
    input  logic         rst,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    // With 16 sets there are no tag bits; keep a 1-bit tag that is always 0.
    localparam int unsigned TAG_W = (IDX_W < MEM_IDX_W) ? MEM_IDX_W - IDX_W : 1;

    state_t r_state, w_state_nxt;

    logic [7:0]       w_addr8;
    logic [1:0]       w_cpu_off;
    logic [3:0]       w_cpu_line;
    logic [3:0]       w_idx_full;
    logic [3:0]       w_tag_full;
    logic [IDX_W-1:0] w_cpu_idx;
    logic [TAG_W-1:0] w_cpu_tag;
    logic             w_unused_bits;

    logic              w_valid;
    logic              w_dirty;
    logic [TAG_W-1:0]  w_tag;
    logic [LINE_W-1:0] w_line;

    logic              w_hit;
    logic              w_ww_en;
    logic              w_fill_en;
    logic              w_miss_latch;
    logic              w_wb_load;
    logic              w_rd_load;
    logic [3:0]        w_rd_addr_nxt;
    logic [WORD_W-1:0] w_rdata;

    // Miss context, frozen at IDLE exit
    logic [IDX_W-1:0] r_miss_idx;
    logic [TAG_W-1:0] r_miss_tag;
    logic [3:0]       r_miss_line;

    logic              r_rd_req;
    logic [3:0]        r_rd_addr;
    logic              r_wb_we;
    logic [3:0]        r_wb_addr;
    logic [LINE_W-1:0] r_wb_wline;

    assign w_addr8    = cpu.cpu_addr[7:0];
    assign w_cpu_off  = addr_offset(w_addr8);
    assign w_cpu_line = addr_line(w_addr8);
    assign w_idx_full = addr_index(w_addr8, IDX_W);
    assign w_tag_full = addr_tag(w_addr8, IDX_W);
    assign w_cpu_idx  = w_idx_full[IDX_W-1:0];
    assign w_cpu_tag  = w_tag_full[TAG_W-1:0];

    // Address bits outside the 256-byte word-aligned space are ignored.
    assign w_unused_bits = ^{cpu.cpu_addr[XLEN-1:8], cpu.cpu_addr[1:0], w_idx_full, w_tag_full};

    dcache_array #(
        .NUM_SETS(NUM_SETS),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_cpu_idx),
        .o_valid    (w_valid),
        .o_dirty    (w_dirty),
        .o_tag      (w_tag),
        .o_line     (w_line),
        .i_ww_en    (w_ww_en),
        .i_ww_idx   (w_cpu_idx),
        .i_ww_off   (w_cpu_off),
        .i_ww_data  (cpu.cpu_wdata[WORD_W-1:0]),
        .i_fill_en  (w_fill_en),
        .i_fill_idx (r_miss_idx),
        .i_fill_tag (r_miss_tag),
        .i_fill_line(mem.Dc_rline)
    );

    assign w_hit   = cpu.cpu_req & w_valid & (w_tag == w_cpu_tag) & (r_state == StIdle);
    assign w_ww_en = w_hit & cpu.cpu_we;

    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            w_rdata = w_line[WORD_W*w_cpu_off +: WORD_W];
        end
    end

    assign cpu.cpu_stall = cpu.cpu_req & ~w_hit;
    assign cpu.cpu_rdata = XLEN'(w_rdata);

    always_comb begin
        w_state_nxt  = r_state;
        w_miss_latch = 1'b0;
        w_wb_load    = 1'b0;
        w_rd_load    = 1'b0;
        w_fill_en    = 1'b0;
        case (r_state)
            StIdle: begin
                if (cpu.cpu_req && !w_hit) begin
                    w_miss_latch = 1'b1;
                    if (w_valid && w_dirty) begin
                        w_wb_load   = 1'b1;
                        w_state_nxt = StWb;
                    end else begin
                        w_rd_load   = 1'b1;
                        w_state_nxt = StReq;
                    end
                end
            end
            StWb: begin
                w_rd_load   = 1'b1;
                w_state_nxt = StReq;
            end
            StReq: begin
                w_state_nxt = StWait;
            end
            StWait: begin
                if (mem.Dc_rd_valid) begin
                    w_fill_en   = 1'b1;
                    w_state_nxt = StFill;
                end
            end
            StFill: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // From IDLE the latched line is not yet available, so take it from the bus.
    assign w_rd_addr_nxt = (r_state == StIdle) ? w_cpu_line : r_miss_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_wline <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_req <= w_rd_load;
            r_wb_we  <= w_wb_load;
            if (w_rd_load) begin
                r_rd_addr <= w_rd_addr_nxt;
            end
            if (w_wb_load) begin
                r_wb_addr  <= make_line(4'(w_tag), 4'(w_cpu_idx), IDX_W);
                r_wb_wline <= w_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss_latch) begin
            r_miss_idx  <= w_cpu_idx;
            r_miss_tag  <= w_cpu_tag;
            r_miss_line <= w_cpu_line;
        end
    end

    assign mem.Dc_rd_req   = r_rd_req;
    assign mem.Dc_rd_addr  = r_rd_addr;
    assign mem.Dc_wb_we    = r_wb_we;
    assign mem.Dc_wb_addr  = r_wb_addr;
    assign mem.Dc_wb_wline = r_wb_wline;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed, table-driven bench for dcache_ctrl with a
// 3-cycle-latency line memory model (line l, word w holds 0x1000_0l0w).
module tb_dcache_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    dcache_cpu_if #(.XLEN(32)) cpu_bus ();
    dcache_mem_if              mem_bus ();

    dcache_ctrl #(
        .XLEN    (32),
        .NUM_SETS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu(cpu_bus),
        .mem(mem_bus)
    );

    // Memory model
    logic [127:0] mem_q [16];
    logic         m_pend;
    logic [1:0]   m_cnt;
    logic [3:0]   m_addr;

    assign mem_bus.Dc_rline    = mem_q[m_addr];
    assign mem_bus.Dc_rd_valid = m_pend && (m_cnt == 2'd0);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int l = 0; l < 16; l++) begin
                for (int w = 0; w < 4; w++) begin
                    mem_q[l][w*32 +: 32] <= 32'h1000_0000 | (l << 8) | w;
                end
            end
            m_pend <= 1'b0;
            m_cnt  <= 2'd0;
            m_addr <= 4'd0;
        end else begin
            if (mem_bus.Dc_wb_we) mem_q[mem_bus.Dc_wb_addr] <= mem_bus.Dc_wb_wline;
            if (mem_bus.Dc_rd_req && !m_pend) begin
                m_pend <= 1'b1;
                m_cnt  <= 2'd2;
                m_addr <= mem_bus.Dc_rd_addr;
            end else if (m_pend) begin
                if (m_cnt == 2'd0) m_pend <= 1'b0;
                else m_cnt <= m_cnt - 2'd1;
            end
        end
    end

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the hit cycle.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int stalls, output logic [31:0] rd,
                          output int n_rd, output logic [3:0] rd_a,
                          output int n_wb, output logic [3:0] wb_a, output logic [31:0] wb_w0);
        logic done;
        stalls = 0; n_rd = 0; n_wb = 0; rd = '0; rd_a = '0; wb_a = '0; wb_w0 = '0;
        done = 1'b0;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mem_bus.Dc_rd_req) begin
                n_rd++;
                rd_a = mem_bus.Dc_rd_addr;
            end
            if (mem_bus.Dc_wb_we) begin
                n_wb++;
                wb_a  = mem_bus.Dc_wb_addr;
                wb_w0 = mem_bus.Dc_wb_wline[31:0];
            end
            if (!cpu_bus.cpu_stall) begin
                rd   = cpu_bus.cpu_rdata;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) stalls = -1;
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_we  = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stalls;
        logic        chk_rd;
        logic [31:0] rdata;
        int          n_rd;
        logic [3:0]  rd_a;
        int          n_wb;
        logic [3:0]  wb_a;
        logic [31:0] wb_w0;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    int          a_stalls, a_nrd, a_nwb;
    logic [31:0] a_rd, a_wbw0;
    logic [3:0]  a_rda, a_wba;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem_init = 1'b1;
        rst = 1'b1;
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = '0;
        cpu_bus.cpu_wdata = '0;

        //          we    addr           wdata         stl chk   rdata         nrd rda    nwb wba    wbw0
        vecs[0]  = '{1'b0, 32'h24,       32'h0,        6, 1'b1, 32'h10000201, 1, 4'd2, 0, 4'd0, 32'h0};
        vecs[1]  = '{1'b0, 32'h28,       32'h0,        0, 1'b1, 32'h10000202, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[2]  = '{1'b1, 32'h10,       32'hDEADBEEF, 6, 1'b0, 32'h0,        1, 4'd1, 0, 4'd0, 32'h0};
        vecs[3]  = '{1'b0, 32'h10,       32'h0,        0, 1'b1, 32'hDEADBEEF, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[4]  = '{1'b0, 32'h50,       32'h0,        7, 1'b1, 32'h10000500, 1, 4'd5, 1, 4'd1, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 32'h10,       32'h0,        6, 1'b1, 32'hDEADBEEF, 1, 4'd1, 0, 4'd0, 32'h0};
        vecs[6]  = '{1'b1, 32'h24,       32'h11111111, 0, 1'b0, 32'h0,        0, 4'd0, 0, 4'd0, 32'h0};
        vecs[7]  = '{1'b0, 32'h24,       32'h0,        0, 1'b1, 32'h11111111, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[8]  = '{1'b1, 32'h28,       32'h22222222, 0, 1'b0, 32'h0,        0, 4'd0, 0, 4'd0, 32'h0};
        vecs[9]  = '{1'b0, 32'h28,       32'h0,        0, 1'b1, 32'h22222222, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[10] = '{1'b0, 32'h24,       32'h0,        0, 1'b1, 32'h11111111, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[11] = '{1'b1, 32'h24,       32'h33333333, 0, 1'b0, 32'h0,        0, 4'd0, 0, 4'd0, 32'h0};
        vecs[12] = '{1'b0, 32'h24,       32'h0,        0, 1'b1, 32'h33333333, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[13] = '{1'b0, 32'h64,       32'h0,        7, 1'b1, 32'h10000601, 1, 4'd6, 1, 4'd2, 32'h10000200};
        vecs[14] = '{1'b0, 32'h28,       32'h0,        6, 1'b1, 32'h22222222, 1, 4'd2, 0, 4'd0, 32'h0};
        vecs[15] = '{1'b0, 32'hFFFFFF29, 32'h0,        0, 1'b1, 32'h22222222, 0, 4'd0, 0, 4'd0, 32'h0};
        vecs[16] = '{1'b0, 32'h20,       32'h0,        0, 1'b1, 32'h10000200, 0, 4'd0, 0, 4'd0, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst Dc_rd_req", mem_bus.Dc_rd_req, 1'b0);
        check("rst Dc_wb_we", mem_bus.Dc_wb_we, 1'b0);
        check("rst Dc_rd_addr", mem_bus.Dc_rd_addr, 4'd0);
        check("rst Dc_wb_addr", mem_bus.Dc_wb_addr, 4'd0);
        check("rst Dc_wb_wline", mem_bus.Dc_wb_wline, 128'd0);
        check("rst stall idle", cpu_bus.cpu_stall, 1'b0);
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_addr = 32'h24;
        #1;
        check("rst stall follows req", cpu_bus.cpu_stall, 1'b1);
        cpu_bus.cpu_req = 1'b0;
        mem_init = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven accesses
        for (int i = 0; i < NV; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   a_stalls, a_rd, a_nrd, a_rda, a_nwb, a_wba, a_wbw0);
            check($sformatf("v%0d stall cycles", i), a_stalls, vecs[i].stalls);
            check($sformatf("v%0d rd_req pulses", i), a_nrd, vecs[i].n_rd);
            if (vecs[i].n_rd > 0) check($sformatf("v%0d Dc_rd_addr", i), a_rda, vecs[i].rd_a);
            check($sformatf("v%0d wb_we pulses", i), a_nwb, vecs[i].n_wb);
            if (vecs[i].n_wb > 0) begin
                check($sformatf("v%0d Dc_wb_addr", i), a_wba, vecs[i].wb_a);
                check($sformatf("v%0d Dc_wb_wline w0", i), a_wbw0, vecs[i].wb_w0);
            end
            if (vecs[i].chk_rd) check($sformatf("v%0d cpu_rdata", i), a_rd, vecs[i].rdata);
        end

        // Reset during WAIT: the late line must not be installed
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = 32'h30;
        #1;
        check("midrst miss stall", cpu_bus.cpu_stall, 1'b1);
        check("midrst miss rdata zero", cpu_bus.cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        #1;
        check("midrst REQ Dc_rd_req", mem_bus.Dc_rd_req, 1'b1);
        check("midrst REQ Dc_rd_addr", mem_bus.Dc_rd_addr, 4'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cpu_bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst Dc_rd_addr cleared", mem_bus.Dc_rd_addr, 4'd0);
        check("midrst Dc_rd_req low", mem_bus.Dc_rd_req, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        access(1'b0, 32'h30, 32'h0, a_stalls, a_rd, a_nrd, a_rda, a_nwb, a_wba, a_wbw0);
        check("midrst reload stall cycles", a_stalls, 6);
        check("midrst reload rd_req pulses", a_nrd, 1);
        check("midrst reload cpu_rdata", a_rd, 32'h10000300);

        // Request dropped while stalled: line still installed
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_addr = 32'hB4;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        cpu_bus.cpu_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        access(1'b0, 32'hB4, 32'h0, a_stalls, a_rd, a_nrd, a_rda, a_nwb, a_wba, a_wbw0);
        check("prefetch hit stall cycles", a_stalls, 0);
        check("prefetch hit rd_req pulses", a_nrd, 0);
        check("prefetch hit cpu_rdata", a_rd, 32'h10000B01);
        access(1'b0, 32'h30, 32'h0, a_stalls, a_rd, a_nrd, a_rda, a_nwb, a_wba, a_wbw0);
        check("evict line3 stall cycles", a_stalls, 6);
        check("evict line3 wb_we pulses", a_nwb, 0);
        check("evict line3 cpu_rdata", a_rd, 32'h10000300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
